vid2stream: RTL and testbench

Converts the raster pixel output of the video timing pattern generator (`hs`, `vs`, `rgb`, `rgb_vld`) into a ready/valid pixel stream with start-of-frame and end-of-line markers, buffered by a small FIFO. It sits directly downstream of the generator. It absorbs backpressure from the consumer, which the raster side cannot tolerate. On overflow it drops pixels and resynchronises at the next frame.

---
 rtl/vid2stream_if.sv | 27 ++
 rtl/vid2stream.sv | 101 ++++++++++
 tb/tb_vid2stream.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vid2stream_if.sv
// Ready/valid pixel stream with start-of-frame and end-of-line markers.
// The master drives the head pixel; the slave returns m_ready.
interface vid2stream_if #(
   parameter int PW = 8
);
   logic [3*PW-1:0] m_data;
   logic            m_sof;
   logic            m_eol;
   logic            m_valid;
   logic            m_ready;

   modport master (
      output m_data,
      output m_sof,
      output m_eol,
      output m_valid,
      input  m_ready
   );

   modport slave (
      input  m_data,
      input  m_sof,
      input  m_eol,
      input  m_valid,
      output m_ready
   );
endinterface

// File: rtl/vid2stream.sv
// Raster pixels to ready/valid stream through a one-entry hold stage and a FWFT FIFO; 2-cycle latency.
// The consumer may stall freely; on FIFO overflow pixels are dropped until the next frame start.
module vid2stream #(
   parameter int PW = 8,
   parameter int AW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            hs,
   input  logic            vs,
   input  logic [3*PW-1:0] rgb,
   input  logic            rgb_vld,
   vid2stream_if.master    strm,
   output logic            overflow,
   input  logic            clr_overflow,
   output logic [AW:0]     level
);
   localparam logic [1:0] WAIT = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DROP = 2'd2;
   localparam int         DW   = 3*PW + 2;

   logic [1:0]      state;
   logic            vsD;
   logic            vsRise;
   logic            capture;
   logic            sofPend;
   logic            holdVld;
   logic            holdSof;
   logic [3*PW-1:0] holdData;
   logic [AW:0]     wptr;
   logic [AW:0]     rptr;
   logic [DW-1:0]   mem [2**AW];
   logic [DW-1:0]   head;
   logic            full;
   logic            pop;
   logic            wrEn;
   logic            drop;
   logic            unusedHsD;

   assign vsRise  = vs & ~vsD;
   // A frame start lets the coincident pixel in even from WAIT/DROP.
   assign capture = rgb_vld & ((state == RUN) | vsRise);

   assign level = wptr - rptr;
   assign full  = level[AW];
   assign pop   = strm.m_valid & strm.m_ready;
   assign wrEn  = holdVld & (~full | pop);
   assign drop  = holdVld & full & ~pop;
   assign head  = mem[rptr[AW-1:0]];

   assign strm.m_valid = |level;
   assign strm.m_data  = strm.m_valid ? head[3*PW-1:0] : '0;
   assign strm.m_eol   = strm.m_valid & head[3*PW];
   assign strm.m_sof   = strm.m_valid & head[3*PW+1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= WAIT;
         vsD       <= 1'b0;
         unusedHsD <= 1'b0;
         sofPend   <= 1'b0;
         holdVld   <= 1'b0;
         holdSof   <= 1'b0;
         holdData  <= '0;
         wptr      <= '0;
         rptr      <= '0;
         overflow  <= 1'b0;
      end else begin
         vsD       <= vs;
         unusedHsD <= hs;
         if (wrEn) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;

         if (drop)              overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;

         if (drop) begin
            state   <= DROP;
            holdVld <= 1'b0;
         end else if (capture) begin
            state    <= RUN;
            holdData <= rgb;
            holdSof  <= sofPend | vsRise;
            holdVld  <= 1'b1;
            sofPend  <= 1'b0;
         end else begin
            holdVld <= 1'b0;
            if (vsRise) begin
               state   <= RUN;
               sofPend <= 1'b1;
            end
         end
      end
   end

   // End-of-line is known only now: no pixel followed the held one this cycle.
   always_ff @(posedge clk) begin
      if (wrEn) mem[wptr[AW-1:0]] <= {holdSof, ~capture, holdData};
   end
endmodule

// File: tb/tb_vid2stream.sv
module tb_vid2stream;
   logic        clk;
   logic        rst;
   logic        hs;
   logic        vs;
   logic [23:0] rgb;
   logic        rgb_vld;
   logic        overflow;
   logic        clr_overflow;
   logic [4:0]  level;
   logic [26:0] obs;
   logic [26:0] expo;
   int          checks;
   int          errors;

   vid2stream_if #(.PW(8)) s ();

   vid2stream #(.PW(8), .AW(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .hs           (hs),
      .vs           (vs),
      .rgb          (rgb),
      .rgb_vld      (rgb_vld),
      .strm         (s),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .level        (level)
   );

   assign obs = {s.m_valid, s.m_sof, s.m_eol, s.m_data};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; vs = 1'b0; hs = 1'b0; rgb_vld = 1'b0; rgb = '0;
      clr_overflow = 1'b0; s.m_ready = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1; vs = 1'b1; hs = 1'b1; rgb_vld = 1'b1; rgb = 24'hFFFFFF;
      clr_overflow = 1'b0; s.m_ready = 1'b1;
      cyc(); cyc(); cyc();
      checks++;
      if (obs !== 27'h0) begin errors++; $display("FAIL reset_obs got %h want %h", obs, 27'h0); end
      checks++;
      if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
   endtask

   task automatic test_basic_line();
      apply_reset();
      s.m_ready = 1'b1;
      vs = 1'b1; cyc();
      vs = 1'b0; cyc();
      for (int k = 0; k < 8; k++) begin
         rgb_vld = (k < 4);
         rgb     = (k < 4) ? 24'(32'h010101 * (k + 1)) : 24'h0;
         expo    = (k >= 2 && k <= 5) ?
                   {1'b1, (k == 2), (k == 5), 24'(32'h010101 * (k - 1))} : 27'h0;
         checks++;
         if (obs !== expo) begin errors++; $display("FAIL basic_beat k=%0d got %h want %h", k, obs, expo); end
         checks++;
         if (level !== ((k >= 2 && k <= 5) ? 5'd1 : 5'd0)) begin
            errors++; $display("FAIL basic_level k=%0d got %0d", k, level);
         end
         cyc();
      end
   endtask

   task automatic test_wait_before_vs();
      apply_reset();
      s.m_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         rgb_vld = 1'b1; rgb = 24'hDEAD00 + 24'(k);
         checks++;
         if (obs !== 27'h0 || level !== 5'd0) begin
            errors++; $display("FAIL wait_nobeat k=%0d got %h level %0d want 0", k, obs, level);
         end
         cyc();
      end
      vs = 1'b1; rgb_vld = 1'b1; rgb = 24'hAA0000; cyc();
      vs = 1'b0; rgb_vld = 1'b0;
      checks++;
      if (obs !== 27'h0) begin errors++; $display("FAIL wait_early got %h want 0", obs); end
      cyc();
      expo = {3'b111, 24'hAA0000};
      checks++;
      if (obs !== expo) begin errors++; $display("FAIL wait_first got %h want %h", obs, expo); end
      cyc();
      checks++;
      if (obs !== 27'h0) begin errors++; $display("FAIL wait_after got %h want 0", obs); end
   endtask

   task automatic test_overflow();
      apply_reset();
      vs = 1'b1; cyc();
      vs = 1'b0; cyc();
      for (int k = 0; k < 24; k++) begin
         rgb_vld = (k < 20); rgb = 24'(k + 1);
         if (k == 17) begin
            checks++;
            if (overflow !== 1'b0 || level !== 5'd16) begin
               errors++; $display("FAIL ovf_pre ovf %b level %0d want 0 16", overflow, level);
            end
         end
         if (k == 18) begin
            checks++;
            if (overflow !== 1'b1 || level !== 5'd16) begin
               errors++; $display("FAIL ovf_set ovf %b level %0d want 1 16", overflow, level);
            end
            expo = {3'b110, 24'd1};
            checks++;
            if (obs !== expo) begin errors++; $display("FAIL ovf_head got %h want %h", obs, expo); end
         end
         cyc();
      end
      for (int k = 0; k < 6; k++) begin
         rgb_vld = 1'b1; rgb = 24'hBAD000 + 24'(k); cyc();
      end
      rgb_vld = 1'b0; cyc(); cyc();
      checks++;
      if (level !== 5'd16) begin errors++; $display("FAIL ovf_discard level %0d want 16", level); end
      s.m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         expo = {1'b1, (i == 0), 1'b0, 24'(i + 1)};
         checks++;
         if (obs !== expo) begin errors++; $display("FAIL ovf_drain i=%0d got %h want %h", i, obs, expo); end
         cyc();
      end
      checks++;
      if (obs !== 27'h0 || level !== 5'd0) begin
         errors++; $display("FAIL ovf_empty got %h level %0d want 0", obs, level);
      end
      vs = 1'b1; rgb_vld = 1'b1; rgb = 24'h000055; cyc();
      vs = 1'b0; rgb = 24'h000056; cyc();
      rgb_vld = 1'b0;
      expo = {3'b110, 24'h000055};
      checks++;
      if (obs !== expo) begin errors++; $display("FAIL ovf_resync0 got %h want %h", obs, expo); end
      cyc();
      expo = {3'b101, 24'h000056};
      checks++;
      if (obs !== expo) begin errors++; $display("FAIL ovf_resync1 got %h want %h", obs, expo); end
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
      clr_overflow = 1'b1; cyc();
      clr_overflow = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
   endtask

   task automatic test_full_push_pop();
      apply_reset();
      vs = 1'b1; cyc();
      vs = 1'b0; cyc();
      for (int k = 0; k < 20; k++) begin
         rgb_vld   = (k < 17);
         rgb       = 24'h000100 + 24'(k);
         s.m_ready = (k >= 17);
         if (k == 17) begin
            checks++;
            if (level !== 5'd16) begin errors++; $display("FAIL full_pre level %0d want 16", level); end
         end
         if (k == 18) begin
            checks++;
            if (level !== 5'd16 || overflow !== 1'b0) begin
               errors++; $display("FAIL full_pushpop level %0d ovf %b want 16 0", level, overflow);
            end
            expo = {3'b100, 24'h000101};
            checks++;
            if (obs !== expo) begin errors++; $display("FAIL full_head got %h want %h", obs, expo); end
         end
         if (k == 19) begin
            checks++;
            if (level !== 5'd15) begin errors++; $display("FAIL full_level15 level %0d want 15", level); end
         end
         cyc();
      end
      for (int i = 0; i < 14; i++) begin
         expo = {1'b1, 1'b0, (i == 13), 24'h000103 + 24'(i)};
         checks++;
         if (obs !== expo) begin errors++; $display("FAIL full_drain i=%0d got %h want %h", i, obs, expo); end
         cyc();
      end
      checks++;
      if (level !== 5'd0) begin errors++; $display("FAIL full_empty level %0d want 0", level); end
   endtask

   task automatic test_single_pixel_lines();
      apply_reset();
      s.m_ready = 1'b1;
      vs = 1'b1; cyc();
      vs = 1'b0; cyc();
      for (int k = 0; k < 13; k++) begin
         rgb_vld = (k % 4 == 0) && (k < 12);
         rgb     = 24'(32'h111111 * (k / 4 + 1));
         expo    = (k % 4 == 2 && k <= 10) ?
                   {1'b1, (k == 2), 1'b1, 24'(32'h111111 * ((k - 2) / 4 + 1))} : 27'h0;
         checks++;
         if (obs !== expo) begin errors++; $display("FAIL single k=%0d got %h want %h", k, obs, expo); end
         cyc();
      end
   endtask

   task automatic test_reset_midline();
      apply_reset();
      vs = 1'b1; cyc();
      vs = 1'b0; cyc();
      for (int k = 0; k < 29; k++) begin
         rgb_vld = 1'b1; rgb = 24'(k + 1); s.m_ready = (k >= 18);
         cyc();
      end
      s.m_ready = 1'b0; rgb_vld = 1'b1;
      checks++;
      if (level !== 5'd5 || overflow !== 1'b1) begin
         errors++; $display("FAIL mid_pre level %0d ovf %b want 5 1", level, overflow);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (s.m_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b0) begin
         errors++; $display("FAIL mid_async valid %b level %0d ovf %b want 0 0 0", s.m_valid, level, overflow);
      end
      @(posedge clk); #1;
      rst = 1'b0; s.m_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         rgb_vld = 1'b1; rgb = 24'h00C000 + 24'(k);
         checks++;
         if (obs !== 27'h0 || level !== 5'd0) begin
            errors++; $display("FAIL mid_wait k=%0d got %h level %0d want 0", k, obs, level);
         end
         cyc();
      end
      vs = 1'b1; rgb = 24'h000077; cyc();
      vs = 1'b0; rgb_vld = 1'b0; cyc();
      expo = {3'b111, 24'h000077};
      checks++;
      if (obs !== expo) begin errors++; $display("FAIL mid_resync got %h want %h", obs, expo); end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1; vs = 1'b0; hs = 1'b0; rgb = '0; rgb_vld = 1'b0;
      clr_overflow = 1'b0; s.m_ready = 1'b0;
      test_reset();
      test_basic_line();
      test_wait_before_vs();
      test_overflow();
      test_full_push_pop();
      test_single_pixel_lines();
      test_reset_midline();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
